// File: rtl/capture_pulse_trigger.sv
// Phase baseline tracker (shift-based IIR) and pulse-peak trigger feeding the capture2 snapshot buffer.
// Optional CAPTURE_PULSE_TRIGGER_TIMESTAMP_EN adds a valid-sample counter and the trig_time output.
module capture_pulse_trigger #(
   parameter int PHASE_W     = 16,
   parameter int FRAC_W      = 20,
   parameter int HOLDOFF_LEN = 64,
   parameter int MAX_RISE    = 255
) (
   input  logic                      user_clk,
   input  logic                      user_rst_n,
   input  logic [31:0]               base_kq_reg,
   input  logic [PHASE_W-1:0]        thresh,
   input  logic signed [PHASE_W-1:0] phase_in,
   input  logic                      phase_valid,
   output logic                      trig,
   output logic signed [PHASE_W:0]   trig_peak,
   output logic signed [PHASE_W-1:0] trig_base,
   output logic                      trig_forced,
   output logic signed [PHASE_W-1:0] baseline_out,
   output logic                      busy
`ifdef CAPTURE_PULSE_TRIGGER_TIMESTAMP_EN
   ,
   output logic [31:0]               trig_time
`endif
);

   localparam int ACC_W  = PHASE_W + FRAC_W + 1;
   localparam int EXT_W  = ACC_W + 1;
   localparam int KMAX   = 20;
   localparam int RISE_W = $clog2(MAX_RISE + 1);
   localparam int HOLD_W = (HOLDOFF_LEN > 1) ? $clog2(HOLDOFF_LEN) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'((HOLDOFF_LEN > 0) ? HOLDOFF_LEN - 1 : 0);
   localparam logic [RISE_W-1:0] RISE_LIMIT = RISE_W'(MAX_RISE);

   typedef enum logic [1:0] {S_IDLE, S_RISE, S_HOLDOFF} state_t;

   state_t                    state, state_next;
   logic signed [ACC_W-1:0]   acc;
   logic signed [EXT_W-1:0]   target_ext, diff_ext, step_ext, sum_ext;
   logic [4:0]                keff;
   logic                      track_en;
   logic signed [PHASE_W:0]   d;
   logic                      d_valid;
   logic signed [PHASE_W:0]   peak, peak_next;
   logic signed [PHASE_W-1:0] base, base_next;
   logic [RISE_W-1:0]         rise_cnt, rise_cnt_next;
   logic [HOLD_W-1:0]         hold_cnt, hold_cnt_next;
   logic                      above_thresh, rising, timeout;
   logic                      fire, fire_forced;
   logic                      unused_reg_bits;

   assign unused_reg_bits = ^base_kq_reg[30:5];

   // The filter only learns while idle, so pulses never pull the baseline toward themselves.
   always_comb begin
      keff = base_kq_reg[4:0];
      if (base_kq_reg[4:0] == 5'd0) begin
         keff = 5'd1;
      end else if (base_kq_reg[4:0] > 5'(KMAX)) begin
         keff = 5'(KMAX);
      end
      track_en   = !base_kq_reg[31] && (state == S_IDLE);
      target_ext = {{(EXT_W - PHASE_W - FRAC_W){phase_in[PHASE_W-1]}}, phase_in, {FRAC_W{1'b0}}};
      diff_ext   = target_ext - {acc[ACC_W-1], acc};
      step_ext   = diff_ext >>> keff;
      sum_ext    = {acc[ACC_W-1], acc} + step_ext;
   end

   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         acc          <= '0;
         baseline_out <= '0;
      end else if (phase_valid && track_en) begin
         acc          <= sum_ext[ACC_W-1:0];
         baseline_out <= sum_ext[FRAC_W +: PHASE_W];
      end
   end

   // Deviation is taken against the baseline as it stood before this sample's filter update.
   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         d       <= '0;
         d_valid <= 1'b0;
      end else begin
         d_valid <= phase_valid;
         if (phase_valid) begin
            d <= {baseline_out[PHASE_W-1], baseline_out} - {phase_in[PHASE_W-1], phase_in};
         end
      end
   end

   always_comb begin
      state_next    = state;
      peak_next     = peak;
      base_next     = base;
      rise_cnt_next = rise_cnt;
      hold_cnt_next = hold_cnt;
      fire          = 1'b0;
      fire_forced   = 1'b0;
      timeout       = 1'b0;
      above_thresh  = d > $signed({1'b0, thresh});
      rising        = d >= peak;
      if (d_valid) begin
         case (state)
            S_IDLE: begin
               if (above_thresh) begin
                  state_next    = S_RISE;
                  peak_next     = d;
                  base_next     = baseline_out;
                  rise_cnt_next = RISE_W'(1);
               end
            end
            S_RISE: begin
               if (rising) begin
                  peak_next     = d;
                  rise_cnt_next = rise_cnt + 1'b1;
               end
               // Timeout wins over a coincident drop so the forced flag is never lost.
               timeout = (rise_cnt_next >= RISE_LIMIT);
               if (!rising || timeout) begin
                  fire          = 1'b1;
                  fire_forced   = timeout;
                  state_next    = S_HOLDOFF;
                  hold_cnt_next = '0;
               end
            end
            S_HOLDOFF: begin
               if (hold_cnt == HOLD_LAST) begin
                  state_next = S_IDLE;
               end else begin
                  hold_cnt_next = hold_cnt + 1'b1;
               end
            end
            default: state_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         state       <= S_IDLE;
         peak        <= '0;
         base        <= '0;
         rise_cnt    <= '0;
         hold_cnt    <= '0;
         trig        <= 1'b0;
         trig_forced <= 1'b0;
         trig_peak   <= '0;
         trig_base   <= '0;
      end else begin
         state       <= state_next;
         peak        <= peak_next;
         base        <= base_next;
         rise_cnt    <= rise_cnt_next;
         hold_cnt    <= hold_cnt_next;
         trig        <= fire;
         trig_forced <= fire_forced;
         if (fire) begin
            trig_peak <= peak_next;
            trig_base <= base;
         end
      end
   end

   assign busy = (state != S_IDLE);

`ifdef CAPTURE_PULSE_TRIGGER_TIMESTAMP_EN
   logic [31:0] sample_cnt, d_time, peak_time;
   logic        peak_take;

   // Each deviation carries the counter value of the sample it came from.
   assign peak_take = d_valid && (((state == S_IDLE) && above_thresh) || ((state == S_RISE) && rising));

   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         sample_cnt <= '0;
         d_time     <= '0;
         peak_time  <= '0;
         trig_time  <= '0;
      end else begin
         if (phase_valid) begin
            sample_cnt <= sample_cnt + 32'd1;
            d_time     <= sample_cnt;
         end
         if (peak_take) begin
            peak_time <= d_time;
         end
         if (fire) begin
            trig_time <= peak_take ? d_time : peak_time;
         end
      end
   end
`endif

endmodule

// File: tb/tb_capture_pulse_trigger.sv
// Directed bench for capture_pulse_trigger; covers trig_time when CAPTURE_PULSE_TRIGGER_TIMESTAMP_EN is defined.
module tb_capture_pulse_trigger;

   logic               user_clk = 1'b0;
   logic               user_rst_n;
   logic [31:0]        base_kq_reg;
   logic [15:0]        thresh;
   logic signed [15:0] phase_in;
   logic               phase_valid;
   logic               trig;
   logic signed [16:0] trig_peak;
   logic signed [15:0] trig_base;
   logic               trig_forced;
   logic signed [15:0] baseline_out;
   logic               busy;
`ifdef CAPTURE_PULSE_TRIGGER_TIMESTAMP_EN
   logic [31:0]        trig_time;
`endif

   int tests_run    = 0;
   int tests_failed = 0;
   int trig_total   = 0;
   int sample_idx   = 0;
   int first_trig_i;
   int trig_snap;
   int peak_idx;
   longint cap_peak, cap_forced, cap_time;
   logic signed [15:0] prev;
   int exp_k [4] = '{250, 375, 437, 468};

   capture_pulse_trigger dut (
      .user_clk     (user_clk),
      .user_rst_n   (user_rst_n),
      .base_kq_reg  (base_kq_reg),
      .thresh       (thresh),
      .phase_in     (phase_in),
      .phase_valid  (phase_valid),
      .trig         (trig),
      .trig_peak    (trig_peak),
      .trig_base    (trig_base),
      .trig_forced  (trig_forced),
      .baseline_out (baseline_out),
      .busy         (busy)
`ifdef CAPTURE_PULSE_TRIGGER_TIMESTAMP_EN
      ,
      .trig_time    (trig_time)
`endif
   );

   always #5 user_clk = ~user_clk;

   always @(negedge user_clk) begin
      if (trig === 1'b1) trig_total++;
   end

   initial begin
      #1ms;
      $display("[TB] FAIL watchdog: observed timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input longint observed, input longint expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int p);
      phase_in    = 16'(p);
      phase_valid = 1'b1;
      @(posedge user_clk);
      #1;
      sample_idx++;
   endtask

   task automatic idleCycle();
      phase_valid = 1'b0;
      @(posedge user_clk);
      #1;
   endtask

   task automatic doReset();
      phase_valid = 1'b0;
      user_rst_n  = 1'b0;
      repeat (2) @(posedge user_clk);
      #1;
      user_rst_n = 1'b1;
      sample_idx = 0;
      @(posedge user_clk);
      #1;
   endtask

   initial begin
      user_rst_n  = 1'b0;
      base_kq_reg = 32'd4;
      thresh      = 16'd100;
      phase_in    = '0;
      phase_valid = 1'b0;
      repeat (3) @(posedge user_clk);
      #1;
      checkOutput("rst_trig", longint'(trig), 0);
      checkOutput("rst_baseline", longint'(baseline_out), 0);
      checkOutput("rst_busy", longint'(busy), 0);
      checkOutput("rst_peak", longint'(trig_peak), 0);
      user_rst_n = 1'b1;
      @(posedge user_clk);
      #1;
      sample_idx = 0;

      // k=4 convergence toward a constant 1000
      prev = '0;
      for (int i = 0; i < 200; i++) begin
         applyStimulus(1000);
         if (i == 0) checkOutput("k4_first_step", longint'(baseline_out), 62);
         checkOutput("k4_monotonic", longint'(baseline_out >= prev), 1);
         prev = baseline_out;
      end
      checkOutput("k4_converged", longint'(baseline_out), 999);
      idleCycle();
      checkOutput("k4_no_trig", longint'(trig_total), 0);

      // Basic pulse with frozen zero baseline
      doReset();
      base_kq_reg = 32'h8000_0004;
      repeat (4) applyStimulus(0);
      applyStimulus(0);
      applyStimulus(-50);
      applyStimulus(-150);
      checkOutput("p1_idle_busy", longint'(busy), 0);
      applyStimulus(-300);
      checkOutput("p1_rise_busy", longint'(busy), 1);
      applyStimulus(-250);
      checkOutput("p1_no_early_trig", longint'(trig), 0);
      applyStimulus(0);
      checkOutput("p1_trig", longint'(trig), 1);
      checkOutput("p1_peak", longint'(trig_peak), 300);
      checkOutput("p1_base", longint'(trig_base), 0);
      checkOutput("p1_forced", longint'(trig_forced), 0);
      applyStimulus(0);
      checkOutput("p1_trig_one_cycle", longint'(trig), 0);
      repeat (62) applyStimulus(0);
      checkOutput("p1_holdoff_busy", longint'(busy), 1);
      applyStimulus(0);
      checkOutput("p1_holdoff_end", longint'(busy), 0);
      checkOutput("p1_frozen_base", longint'(baseline_out), 0);
      checkOutput("p1_trig_count", longint'(trig_total), 1);

      // Holdoff suppression, then a pulse 70 samples after trig
      applyStimulus(-200);
      applyStimulus(-300);
      applyStimulus(-200);
      applyStimulus(0);
      checkOutput("p2_trig", longint'(trig), 1);
      repeat (9) applyStimulus(0);
      applyStimulus(-200);
      applyStimulus(-300);
      applyStimulus(-200);
      repeat (56) applyStimulus(0);
      checkOutput("p2_ignored", longint'(trig_total), 2);
      applyStimulus(-200);
      applyStimulus(-300);
      applyStimulus(-200);
      applyStimulus(0);
      checkOutput("p3_trig", longint'(trig), 1);
      checkOutput("p3_peak", longint'(trig_peak), 300);
      // A deep sample landing in the last holdoff slot must not start a pulse
      repeat (62) applyStimulus(0);
      applyStimulus(-300);
      repeat (5) applyStimulus(0);
      checkOutput("p3_last_holdoff_ignored", longint'(trig_total), 3);
      checkOutput("p3_idle_after", longint'(busy), 0);

      // Ever-deepening pulse hits the MAX_RISE timeout
      doReset();
      base_kq_reg  = 32'h8000_0004;
      repeat (2) applyStimulus(0);
      first_trig_i = -1;
      peak_idx     = -1;
      cap_peak     = 0;
      cap_forced   = 0;
      cap_time     = 0;
      for (int i = 0; i < 300; i++) begin
         if (i == 254) peak_idx = sample_idx;
         applyStimulus(-(101 + i));
         if (trig === 1'b1 && first_trig_i < 0) begin
            first_trig_i = i;
            cap_peak     = longint'(trig_peak);
            cap_forced   = longint'(trig_forced);
`ifdef CAPTURE_PULSE_TRIGGER_TIMESTAMP_EN
            cap_time     = longint'(trig_time);
`endif
         end
      end
      checkOutput("to_trig_sample", longint'(first_trig_i), 255);
      checkOutput("to_peak", cap_peak, 355);
      checkOutput("to_forced", cap_forced, 1);
`ifdef CAPTURE_PULSE_TRIGGER_TIMESTAMP_EN
      checkOutput("to_trig_time", cap_time, longint'(peak_idx));
`endif
      repeat (70) applyStimulus(0);
      checkOutput("to_single_trig", longint'(trig_total), 4);

      // Freeze holds baseline; k=0 then matches k=1
      doReset();
      base_kq_reg = 32'h8000_0004;
      applyStimulus(0);
      repeat (5) applyStimulus(500);
      checkOutput("frz_baseline", longint'(baseline_out), 0);
      base_kq_reg = 32'h0000_0000;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(500);
         checkOutput("k0_step", longint'(baseline_out), longint'(exp_k[i]));
      end
      doReset();
      base_kq_reg = 32'h0000_0001;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(500);
         checkOutput("k1_step", longint'(baseline_out), longint'(exp_k[i]));
      end

      // Pulse against a nonzero frozen baseline, then reset in the middle of RISE
      base_kq_reg = 32'h8000_0001;
      repeat (3) applyStimulus(500);
      applyStimulus(268);
      applyStimulus(168);
      applyStimulus(268);
      applyStimulus(500);
      checkOutput("nb_trig", longint'(trig), 1);
      checkOutput("nb_peak", longint'(trig_peak), 300);
      checkOutput("nb_base", longint'(trig_base), 468);
      repeat (70) applyStimulus(500);
      applyStimulus(268);
      applyStimulus(168);
      checkOutput("mr_in_rise", longint'(busy), 1);
      applyStimulus(100);
      idleCycle();
      trig_snap  = trig_total;
      user_rst_n = 1'b0;
      phase_in   = 16'sd50;
      #1;
      checkOutput("mr_trig", longint'(trig), 0);
      checkOutput("mr_peak", longint'(trig_peak), 0);
      checkOutput("mr_base", longint'(trig_base), 0);
      checkOutput("mr_forced", longint'(trig_forced), 0);
      checkOutput("mr_baseline", longint'(baseline_out), 0);
      checkOutput("mr_busy", longint'(busy), 0);
      for (int i = 0; i < 4; i++) begin
         phase_valid = ~phase_valid;
         @(posedge user_clk);
         #1;
      end
      checkOutput("mr_hold_trig", longint'(trig), 0);
      user_rst_n = 1'b1;
      phase_in   = '0;
      for (int i = 0; i < 12; i++) begin
         phase_valid = (i % 3) != 1;
         @(posedge user_clk);
         #1;
      end
      phase_valid = 1'b0;
      checkOutput("mr_no_trig", longint'(trig_total), longint'(trig_snap));
      checkOutput("mr_idle", longint'(busy), 0);
      checkOutput("mr_baseline_after", longint'(baseline_out), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
